rc_channel_decoder: RTL and testbench

- Consumes the per-channel pulse-width records produced by the RC capture stage and range-checks each pulse.
- Converts each valid width to a signed position about a centre value and holds the latest position per channel.
- Runs a per-channel signal-loss timeout and raises failsafe when any required channel is lost.
- Results are exposed through a synchronous read port for the control logic.

---
 rtl/rc_channel_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_rc_channel_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_channel_decoder.sv
// rc_channel_decoder
//   Takes per-channel pulse-width records from the RC capture stage, range-checks
//   each one, converts accepted widths to a signed position about CENTER and keeps
//   the latest position per channel. Each channel has a signal-loss timer, and
//   failsafe is raised while any channel in REQ_MASK has timed out.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   in_ctrl       channel index of the offered record (bit 3 marks an invalid record)
//   in_data       pulse length in [LEN-1:0]; the upper bits are ignored
//   in_wr         record offered; held high until in_wr_rdy is seen
//   in_wr_rdy     one-cycle accept pulse (also given for rejected records)
//   rd_addr       channel to read
//   rd_data       signed position of rd_addr, one cycle after rd_addr
//   valid_mask    per-channel "signal present"
//   failsafe      any REQ_MASK channel not present
//   upd_stb       one-cycle pulse when a channel value is committed
//   err_cnt       saturating count of rejected records
module rc_channel_decoder #(
    parameter int                  CHANNELS  = 6,
    parameter int                  LEN       = 17,
    parameter int                  CENTER    = 1500,
    parameter int                  MIN_VALID = 800,
    parameter int                  MAX_VALID = 2200,
    parameter int                  TIMEOUT   = 2500000,
    parameter int                  TO_W      = 22,
    parameter logic [CHANNELS-1:0] REQ_MASK  = 6'b001111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_ctrl,
    input  logic [23:0]         in_data,
    input  logic                in_wr,
    output logic                in_wr_rdy,
    input  logic [2:0]          rd_addr,
    output logic [15:0]         rd_data,
    output logic [CHANNELS-1:0] valid_mask,
    output logic                failsafe,
    output logic                upd_stb,
    output logic [7:0]          err_cnt
);

    // diff is one bit wider than the length so that length - CENTER stays signed
    localparam int DW = LEN + 1;
    localparam logic signed [DW-1:0] CENTER_S  = DW'(CENTER);
    localparam logic signed [DW-1:0] POS_MAX   = DW'(32767);
    localparam logic signed [DW-1:0] POS_MIN   = DW'(-32768);
    localparam logic [LEN-1:0]       MIN_L     = LEN'(MIN_VALID);
    localparam logic [LEN-1:0]       MAX_L     = LEN'(MAX_VALID);
    localparam logic [3:0]           CH_LIM    = 4'(CHANNELS);
    localparam logic [TO_W-1:0]      TIMEOUT_T = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COMMIT
    } state_t;

    state_t state_reg, state_next;

    logic                 accept;
    logic                 in_wr_rdy_reg;
    logic                 upd_stb_reg;
    logic [7:0]           err_cnt_reg;
    logic [3:0]           ctrl_reg;
    logic [LEN-1:0]       len_reg;
    logic                 reject_reg;
    logic                 reject_calc;
    logic signed [DW-1:0] diff_reg;
    logic signed [DW-1:0] diff_calc;
    logic signed [15:0]   pos_clamped;
    logic                 commit_en;

    logic signed [15:0]   position_reg [CHANNELS];
    logic [15:0]          rd_data_reg;
    logic [CHANNELS-1:0]  valid_next;
    logic [CHANNELS-1:0]  valid_mask_reg;
    logic                 failsafe_reg;

    // Upper in_data bits carry no information for this block.
    logic unused_in_data;
    assign unused_in_data = ^in_data[23:LEN];

    // ------------------------------------------------------------------
    // Record FSM: IDLE -> CHECK -> COMMIT -> IDLE
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_wr) begin
                    accept     = 1'b1;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK:  state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        reject_calc = ctrl_reg[3]
                   || ({1'b0, ctrl_reg[2:0]} >= CH_LIM)
                   || (len_reg < MIN_L)
                   || (len_reg > MAX_L);
        diff_calc   = $signed({1'b0, len_reg}) - CENTER_S;
    end

    always_comb begin
        pos_clamped = diff_reg[15:0];
        if (diff_reg > POS_MAX) begin
            pos_clamped = 16'sh7fff;
        end else if (diff_reg < POS_MIN) begin
            pos_clamped = 16'sh8000;
        end
    end

    assign commit_en = (state_reg == ST_COMMIT) && !reject_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            in_wr_rdy_reg <= 1'b0;
            upd_stb_reg   <= 1'b0;
            err_cnt_reg   <= 8'd0;
            ctrl_reg      <= 4'd0;
            len_reg       <= '0;
            reject_reg    <= 1'b0;
            diff_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            in_wr_rdy_reg <= accept;
            upd_stb_reg   <= commit_en;
            if (accept) begin
                ctrl_reg <= in_ctrl;
                len_reg  <= in_data[LEN-1:0];
            end
            if (state_reg == ST_CHECK) begin
                reject_reg <= reject_calc;
                diff_reg   <= diff_calc;
            end
            if ((state_reg == ST_COMMIT) && reject_reg && (err_cnt_reg != 8'hff)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Position store with registered read. A same-cycle commit is not
    // forwarded: the read returns the value held before the write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                position_reg[i] <= '0;
            end
            rd_data_reg <= '0;
        end else begin
            if (commit_en) begin
                position_reg[ctrl_reg[2:0]] <= pos_clamped;
            end
            if ({1'b0, rd_addr} < CH_LIM) begin
                rd_data_reg <= position_reg[rd_addr];
            end else begin
                rd_data_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel loss timers, saturating at TIMEOUT. A commit in the same
    // cycle overrides the increment.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [TO_W-1:0] timer_reg;
            logic [TO_W-1:0] timer_next;
            logic            commit_hit;

            assign commit_hit = commit_en && (ctrl_reg[2:0] == 3'(gi));

            always_comb begin
                timer_next = timer_reg;
                if (commit_hit) begin
                    timer_next = '0;
                end else if (timer_reg < TIMEOUT_T) begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    timer_reg <= TIMEOUT_T;
                end else begin
                    timer_reg <= timer_next;
                end
            end

            // Derived from the next timer value so valid_mask changes on the
            // same edge as the commit (and drops exactly TIMEOUT cycles later).
            assign valid_next[gi] = (timer_next < TIMEOUT_T);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_mask_reg <= '0;
            failsafe_reg   <= 1'b1;
        end else begin
            valid_mask_reg <= valid_next;
            failsafe_reg   <= |(~valid_next & REQ_MASK);
        end
    end

    assign in_wr_rdy  = in_wr_rdy_reg;
    assign upd_stb    = upd_stb_reg;
    assign err_cnt    = err_cnt_reg;
    assign rd_data    = rd_data_reg;
    assign valid_mask = valid_mask_reg;
    assign failsafe   = failsafe_reg;

endmodule

// File: tb/tb_rc_channel_decoder.sv
module tb_rc_channel_decoder;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_ctrl;
    logic [23:0] in_data;
    logic        in_wr;
    logic        in_wr_rdy;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [5:0]  valid_mask;
    logic        failsafe;
    logic        upd_stb;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    rc_channel_decoder #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .in_wr      (in_wr),
        .in_wr_rdy  (in_wr_rdy),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .valid_mask (valid_mask),
        .failsafe   (failsafe),
        .upd_stb    (upd_stb),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        int ch;
        int pos;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   exp_pos [8];
    int   commit_cyc [8];
    int   exp_err   = 0;
    int   rdy_cyc   = -100;
    int   rdy_count = 0;
    int   upd_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
        $display("check %s: got %0d expected %0d", tag, obs, req);
    endtask

    // Scoreboard: every committed record must match the head of the queue,
    // and upd_stb must follow its accept pulse by exactly two cycles.
    always @(negedge clk) begin
        exp_t e;
        if (in_wr_rdy === 1'b1) begin
            rdy_cyc = cyc;
            rdy_count++;
        end
        if (upd_stb === 1'b1) begin
            upd_count++;
            chk("upd_latency", cyc - rdy_cyc, 2);
            chk("sb_nonempty", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_pos[e.ch]    = e.pos;
                commit_cyc[e.ch] = cyc;
            end
        end
    end

    // Bench-side model of the range check; queues the expected commit.
    task automatic model_record(input logic [3:0] ctrl, input logic [23:0] data);
        int   len;
        exp_t e;
        len = int'(data[16:0]);
        if (!ctrl[3] && int'(ctrl[2:0]) < 6 && len >= 800 && len <= 2200) begin
            e.ch  = int'(ctrl[2:0]);
            e.pos = len - 1500;
            sb_q.push_back(e);
        end else if (exp_err < 255) begin
            exp_err++;
        end
    endtask

    task automatic wait_rdy(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_wr_rdy === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk(tag, in_wr_rdy, 1'b1);
    endtask

    task automatic send(input logic [3:0] ctrl, input logic [23:0] data);
        int at;
        model_record(ctrl, data);
        @(posedge clk); #1;
        in_ctrl = ctrl;
        in_data = data;
        in_wr   = 1'b1;
        wait_rdy("send_rdy", at);
        @(posedge clk); #1;
        in_wr = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input int addr, input int req, input string tag);
        @(posedge clk); #1;
        rd_addr = 3'(addr);
        @(posedge clk);
        @(negedge clk);
        chk(tag, $signed(rd_data), req);
    endtask

    task automatic wait_drop(input int ch, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (valid_mask[ch] === 1'b0) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy0, upd0, at, prev;
        logic [23:0] b2b_data [6];

        // ---- reset with in_wr asserted: rst wins ----
        rst     = 1'b1;
        in_wr   = 1'b1;
        in_ctrl = 4'd2;
        in_data = 24'd1750;
        rd_addr = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", in_wr_rdy, 1'b0);
        in_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_mask", valid_mask, 6'b000000);
        chk("rst_failsafe", failsafe, 1'b1);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_upd_stb", upd_stb, 1'b0);
        for (int a = 0; a < 8; a++) rd_chk(a, 0, "rst_rd");
        chk("idle_rdy", rdy_count, 0);

        // ---- single valid record ----
        rdy0 = rdy_count; upd0 = upd_count;
        send(4'd2, 24'd1750);
        chk("ch2_rdy_pulses", rdy_count - rdy0, 1);
        chk("ch2_upd_pulses", upd_count - upd0, 1);
        rd_chk(2, 250, "ch2_pos");
        chk("ch2_valid", valid_mask[2], 1'b1);
        rd_chk(1, 0, "ch1_untouched");
        send(4'd3, 24'hFE06D6);          // upper bits set, length 1750
        rd_chk(3, 250, "upper_bits_ignored");

        // ---- boundaries and rejects ----
        send(4'd0, 24'd800);
        rd_chk(0, -700, "min_valid");
        send(4'd0, 24'd2200);
        rd_chk(0, 700, "max_valid");
        rdy0 = rdy_count; upd0 = upd_count;
        send(4'd0, 24'd799);
        send(4'd0, 24'd2201);
        send(4'd6, 24'd1500);
        send(4'd8, 24'd1500);
        chk("rej_rdy_pulses", rdy_count - rdy0, 4);
        chk("rej_upd_pulses", upd_count - upd0, 0);
        chk("rej_err_cnt", err_cnt, 8'd4);
        chk("rej_err_model", err_cnt, exp_err);
        rd_chk(0, 700, "rej_value_kept");
        for (int i = 0; i < 256; i++) send(4'd1, 24'd100);
        chk("err_saturate", err_cnt, 8'd255);
        chk("err_sat_model", err_cnt, exp_err);

        // ---- timeouts (all earlier channels have long since expired) ----
        send(4'd4, 24'd1600);
        send(4'd1, 24'd1400);
        send(4'd0, 24'd1500);
        send(4'd2, 24'd1500);
        send(4'd3, 24'd1500);
        chk("to_failsafe_clear", failsafe, 1'b0);
        chk("to_mask_all", valid_mask, 6'b011111);
        repeat (40) @(posedge clk);
        send(4'd0, 24'd1500);
        send(4'd2, 24'd1500);
        send(4'd3, 24'd1500);
        wait_drop(4, at);
        chk("ch4_drop_time", at - commit_cyc[4], TMO);
        chk("ch4_drop_failsafe", failsafe, 1'b0);
        chk("ch4_drop_mask", valid_mask, 6'b001111);
        wait_drop(1, at);
        chk("ch1_drop_time", at - commit_cyc[1], TMO);
        chk("ch1_drop_failsafe", failsafe, 1'b1);
        chk("ch1_drop_mask", valid_mask, 6'b001101);
        send(4'd1, 24'd1510);
        chk("ch1_refresh_failsafe", failsafe, 1'b0);
        rd_chk(1, 10, "ch1_refresh_pos");

        // ---- back-to-back records with in_wr held ----
        b2b_data[0] = 24'd1000; b2b_data[1] = 24'd1100; b2b_data[2] = 24'd1900;
        b2b_data[3] = 24'd2000; b2b_data[4] = 24'd1234; b2b_data[5] = 24'd1777;
        for (int i = 0; i < 6; i++) model_record(4'(i), b2b_data[i]);
        rdy0 = rdy_count; upd0 = upd_count;
        @(posedge clk); #1;
        in_ctrl = 4'd0;
        in_data = b2b_data[0];
        in_wr   = 1'b1;
        prev    = -1;
        for (int i = 0; i < 6; i++) begin
            wait_rdy("b2b_rdy", at);
            if (i > 0) chk("b2b_spacing", at - prev, 3);
            prev = at;
            @(posedge clk); #1;
            if (i < 5) begin
                in_ctrl = 4'(i + 1);
                in_data = b2b_data[i + 1];
            end else begin
                in_wr = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b2b_rdy_pulses", rdy_count - rdy0, 6);
        chk("b2b_upd_pulses", upd_count - upd0, 6);
        chk("b2b_sb_empty", sb_q.size(), 0);
        chk("b2b_mask", valid_mask, 6'b111111);
        for (int i = 0; i < 6; i++) rd_chk(i, exp_pos[i], "b2b_pos");
        rd_chk(5, 277, "b2b_ch5_const");

        // ---- reset in the CHECK cycle of a record ----
        @(posedge clk); #1;
        in_ctrl = 4'd3;
        in_data = 24'd1600;
        in_wr   = 1'b1;
        wait_rdy("abort_rdy", at);      // now in CHECK
        rst   = 1'b1;
        in_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 0;
        for (int i = 0; i < 8; i++) exp_pos[i] = 0;
        upd0 = upd_count;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_no_upd", upd_count - upd0, 0);
        chk("abort_mask", valid_mask, 6'b000000);
        chk("abort_failsafe", failsafe, 1'b1);
        chk("abort_err_cnt", err_cnt, 8'd0);
        rd_chk(3, 0, "abort_pos3");
        send(4'd5, 24'd1234);
        chk("after_abort_upd", upd_count - upd0, 1);
        rd_chk(5, -266, "after_abort_pos");
        chk("after_abort_mask", valid_mask, 6'b100000);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
